// File: rtl/clock_mode_ctrl_if.sv
// Button inputs and mode-decode outputs of the clock mode controller.
// slave: controller side; master: button/display side.
interface clock_mode_ctrl_if;
    logic       mode;
    logic       set;
    logic       h1224;
    logic       clock_on;
    logic       alarm_on;
    logic       hset;
    logic       mset;
    logic       sset;
    logic       ahset;
    logic       amset;
    logic [1:0] alarm_idx;
    logic [1:0] sel;
    logic       display_mode;
    logic       fmt24;
    logic       cset_pulse;
    logic       alset_pulse;
    logic       timeout_pulse;

    modport slave (
        input  mode, set, h1224,
        output clock_on, alarm_on,
        output hset, mset, sset, ahset, amset,
        output alarm_idx, sel,
        output display_mode, fmt24,
        output cset_pulse, alset_pulse, timeout_pulse
    );

    modport master (
        output mode, set, h1224,
        input  clock_on, alarm_on,
        input  hset, mset, sset, ahset, amset,
        input  alarm_idx, sel,
        input  display_mode, fmt24,
        input  cset_pulse, alset_pulse, timeout_pulse
    );
endinterface

// File: rtl/clock_mode_ctrl.sv
// Clock mode controller: button-driven mode FSM with set-state timeout.
// Define CLOCK_SECONDS_SET_EN to include the seconds-set state.
module clock_mode_ctrl #(
    parameter int NUM_ALARMS     = 2,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic              clk,
    input  logic              reset_n,
    clock_mode_ctrl_if.slave  bus
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LIM =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [1:0] IDX_MAX = 2'(NUM_ALARMS - 1);

    typedef enum logic [3:0] {
        RUN,
        C_SET_H,
        C_SET_M,
`ifdef CLOCK_SECONDS_SET_EN
        C_SET_S,
`endif
        AL_VIEW,
        AL_SET_H,
        AL_SET_M,
        STOPWATCH,
        ALT_DISPLAY
    } state_t;

    state_t          st_q, st_d;
    logic [1:0]      idx_q, idx_d;
    logic            fmt_q, fmt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            cp_q, cp_d;
    logic            ap_q, ap_d;
    logic            tp_q, tp_d;
    logic            mode_q, set_q, h_q;

    logic            mode_p, set_p, h_p, any_p;
    logic            in_cset, in_aset, in_al;
    logic            to_hit;

    assign mode_p = bus.mode  & ~mode_q;
    assign set_p  = bus.set   & ~set_q;
    assign h_p    = bus.h1224 & ~h_q;
    assign any_p  = mode_p | set_p | h_p;

`ifdef CLOCK_SECONDS_SET_EN
    assign in_cset = (st_q == C_SET_H) || (st_q == C_SET_M) ||
                     (st_q == C_SET_S);
`else
    assign in_cset = (st_q == C_SET_H) || (st_q == C_SET_M);
`endif
    assign in_aset = (st_q == AL_SET_H) || (st_q == AL_SET_M);
    assign in_al   = in_aset || (st_q == AL_VIEW);

    // Timeout fires only in edit states and only when enabled.
    assign to_hit = (TIMEOUT_CYCLES != 0) && (in_cset || in_aset) &&
                    (cnt_q == LIM);

    // Next-state: mode beats set, any press beats timeout.
    always_comb begin
        st_d  = st_q;
        idx_d = idx_q;
        fmt_d = fmt_q;
        cp_d  = 1'b0;
        ap_d  = 1'b0;
        tp_d  = 1'b0;
        if (mode_p) begin
            if (st_q == RUN || in_cset) begin
                st_d  = AL_VIEW;
                idx_d = 2'd0;
            end else if (in_al) begin
                if (idx_q < IDX_MAX) begin
                    st_d  = AL_VIEW;
                    idx_d = idx_q + 2'd1;
                end else begin
                    st_d  = STOPWATCH;
                    idx_d = 2'd0;
                end
            end else if (st_q == STOPWATCH) begin
                st_d = ALT_DISPLAY;
            end else begin
                st_d = RUN;
            end
        end else if (set_p) begin
            unique case (st_q)
                RUN:      st_d = C_SET_H;
                C_SET_H:  st_d = C_SET_M;
`ifdef CLOCK_SECONDS_SET_EN
                C_SET_M:  st_d = C_SET_S;
                C_SET_S: begin
                    st_d = RUN;
                    cp_d = 1'b1;
                end
`else
                C_SET_M: begin
                    st_d = RUN;
                    cp_d = 1'b1;
                end
`endif
                AL_VIEW:  st_d = AL_SET_H;
                AL_SET_H: st_d = AL_SET_M;
                AL_SET_M: begin
                    st_d = AL_VIEW;
                    ap_d = 1'b1;
                end
                default:  st_d = st_q;
            endcase
        end else if (to_hit && !h_p) begin
            st_d = in_cset ? RUN : AL_VIEW;
            tp_d = 1'b1;
        end
        if (h_p && st_q == RUN) begin
            fmt_d = ~fmt_q;
        end
    end

    // Inactivity counter: cleared by presses and state changes.
    always_comb begin
        cnt_d = cnt_q;
        if (any_p || st_d != st_q) begin
            cnt_d = '0;
        end else if ((in_cset || in_aset) && (TIMEOUT_CYCLES != 0) &&
                     (cnt_q != LIM)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // State, edge-detect and pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q   <= RUN;
            idx_q  <= 2'd0;
            fmt_q  <= 1'b1;
            cnt_q  <= '0;
            cp_q   <= 1'b0;
            ap_q   <= 1'b0;
            tp_q   <= 1'b0;
            mode_q <= 1'b0;
            set_q  <= 1'b0;
            h_q    <= 1'b0;
        end else begin
            st_q   <= st_d;
            idx_q  <= idx_d;
            fmt_q  <= fmt_d;
            cnt_q  <= cnt_d;
            cp_q   <= cp_d;
            ap_q   <= ap_d;
            tp_q   <= tp_d;
            mode_q <= bus.mode;
            set_q  <= bus.set;
            h_q    <= bus.h1224;
        end
    end

    // Output decode of the registered state.
    always_comb begin
        bus.clock_on     = 1'b0;
        bus.alarm_on     = 1'b0;
        bus.hset         = 1'b0;
        bus.mset         = 1'b0;
        bus.sset         = 1'b0;
        bus.ahset        = 1'b0;
        bus.amset        = 1'b0;
        bus.sel          = 2'b01;
        bus.display_mode = 1'b0;
        unique case (st_q)
            RUN: begin
                bus.clock_on = 1'b1;
                bus.alarm_on = 1'b1;
            end
            C_SET_H: bus.hset = 1'b1;
            C_SET_M: bus.mset = 1'b1;
`ifdef CLOCK_SECONDS_SET_EN
            C_SET_S: bus.sset = 1'b1;
`endif
            AL_VIEW: begin
                bus.clock_on = 1'b1;
                bus.alarm_on = 1'b1;
                bus.sel      = 2'b00;
            end
            AL_SET_H: begin
                bus.clock_on = 1'b1;
                bus.ahset    = 1'b1;
                bus.sel      = 2'b00;
            end
            AL_SET_M: begin
                bus.clock_on = 1'b1;
                bus.amset    = 1'b1;
                bus.sel      = 2'b00;
            end
            STOPWATCH: begin
                bus.clock_on = 1'b1;
                bus.alarm_on = 1'b1;
                bus.sel      = 2'b11;
            end
            ALT_DISPLAY: begin
                bus.clock_on     = 1'b1;
                bus.alarm_on     = 1'b1;
                bus.display_mode = 1'b1;
                bus.sel          = 2'b10;
            end
            default: bus.sel = 2'b01;
        endcase
    end

    assign bus.alarm_idx     = in_al ? idx_q : 2'd0;
    assign bus.fmt24         = fmt_q;
    assign bus.cset_pulse    = cp_q;
    assign bus.alset_pulse   = ap_q;
    assign bus.timeout_pulse = tp_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Bench for clock_mode_ctrl: directed steps plus random buttons
// checked against a page/field reference model.
module tb_clock_mode_ctrl;

    localparam int NA = 3;
    localparam int TO = 8;
`ifdef CLOCK_SECONDS_SET_EN
    localparam bit SECS = 1'b1;
`else
    localparam bit SECS = 1'b0;
`endif

    localparam int S_RUN = 0, S_CH = 1, S_CM = 2, S_CS = 3;
    localparam int S_AV = 4, S_AH = 5, S_AM = 6;
    localparam int S_SW = 7, S_ALT = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    clock_mode_ctrl_if bus ();

    clock_mode_ctrl #(
        .NUM_ALARMS    (NA),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int ms, midx, mcnt;
    bit mfmt, mcp, map, mtp, pm, ps, ph;

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0b exp=%0b", tag, got, exp);
        end
    endtask

    task automatic chk2(input string tag, input logic [1:0] got,
                        input logic [1:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        ms = S_RUN; midx = 0; mcnt = 0; mfmt = 1'b1;
        mcp = 1'b0; map = 1'b0; mtp = 1'b0;
        pm = 1'b0; ps = 1'b0; ph = 1'b0;
    endtask

    task automatic model_step(input bit m, input bit s, input bit h);
        bit mp, sp, hp, inset;
        int ns, ni;
        mp = m && !pm;
        sp = s && !ps;
        hp = h && !ph;
        ns = ms; ni = midx;
        mcp = 1'b0; map = 1'b0; mtp = 1'b0;
        inset = ms inside {S_CH, S_CM, S_CS, S_AH, S_AM};
        if (mp) begin
            if (ms <= S_CS) begin
                ns = S_AV; ni = 0;
            end else if (ms <= S_AM) begin
                if (midx < NA - 1) begin
                    ns = S_AV; ni = midx + 1;
                end else begin
                    ns = S_SW; ni = 0;
                end
            end else if (ms == S_SW) ns = S_ALT;
            else ns = S_RUN;
        end else if (sp) begin
            case (ms)
                S_RUN: ns = S_CH;
                S_CH:  ns = S_CM;
                S_CM: begin
                    if (SECS) ns = S_CS;
                    else begin ns = S_RUN; mcp = 1'b1; end
                end
                S_CS:  begin ns = S_RUN; mcp = 1'b1; end
                S_AV:  ns = S_AH;
                S_AH:  ns = S_AM;
                S_AM:  begin ns = S_AV; map = 1'b1; end
                default: ns = ms;
            endcase
        end else if (!hp && inset && mcnt == TO - 1) begin
            ns = (ms <= S_CS) ? S_RUN : S_AV;
            mtp = 1'b1;
        end
        if (hp && ms == S_RUN) mfmt = !mfmt;
        if (mp || sp || hp || ns != ms) mcnt = 0;
        else if (inset) mcnt++;
        ms = ns; midx = ni;
        pm = m; ps = s; ph = h;
    endtask

    task automatic check_all(input string t);
        bit cs, al;
        logic [1:0] esel;
        cs = ms inside {S_CH, S_CM, S_CS};
        al = ms inside {S_AV, S_AH, S_AM};
        if (al) esel = 2'b00;
        else if (ms == S_SW) esel = 2'b11;
        else if (ms == S_ALT) esel = 2'b10;
        else esel = 2'b01;
        chk1({t, ".clock_on"}, bus.clock_on, !cs);
        chk1({t, ".alarm_on"}, bus.alarm_on,
             ms inside {S_RUN, S_AV, S_SW, S_ALT});
        chk1({t, ".hset"}, bus.hset, ms == S_CH);
        chk1({t, ".mset"}, bus.mset, ms == S_CM);
        chk1({t, ".sset"}, bus.sset, ms == S_CS);
        chk1({t, ".ahset"}, bus.ahset, ms == S_AH);
        chk1({t, ".amset"}, bus.amset, ms == S_AM);
        chk2({t, ".sel"}, bus.sel, esel);
        chk2({t, ".alarm_idx"}, bus.alarm_idx, al ? 2'(midx) : 2'd0);
        chk1({t, ".display_mode"}, bus.display_mode, ms == S_ALT);
        chk1({t, ".fmt24"}, bus.fmt24, mfmt);
        chk1({t, ".cset_pulse"}, bus.cset_pulse, mcp);
        chk1({t, ".alset_pulse"}, bus.alset_pulse, map);
        chk1({t, ".timeout_pulse"}, bus.timeout_pulse, mtp);
    endtask

    task automatic tick(input bit m, input bit s, input bit h);
        bus.mode = m;
        bus.set = s;
        bus.h1224 = h;
        model_step(m, s, h);
        @(posedge clk);
        #1;
        check_all("tick");
    endtask

    task automatic press(input bit m, input bit s, input bit h);
        tick(m, s, h);
        tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic async_reset();
        bus.mode = 1'b0;
        bus.set = 1'b0;
        bus.h1224 = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        #3 reset_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
    endtask

    int ncp;
    int pct;

    initial begin
        bus.mode = 1'b0;
        bus.set = 1'b0;
        bus.h1224 = 1'b0;
        model_reset();
        #12;
        check_all("rst_low");
        @(negedge clk);
        reset_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        chk1("r026.clock_on", bus.clock_on, 1'b1);
        chk1("r026.alarm_on", bus.alarm_on, 1'b1);
        chk2("r026.sel", bus.sel, 2'b01);
        chk1("r026.fmt24", bus.fmt24, 1'b1);

        for (int k = 0; k < 5; k++) begin
            tick(1'b1, 1'b0, 1'b0);
            if (k < 3) begin
                chk2("r027.sel_al", bus.sel, 2'b00);
                chk2("r027.idx", bus.alarm_idx, 2'(k));
            end else if (k == 3) begin
                chk2("r027.sel_sw", bus.sel, 2'b11);
            end else begin
                chk1("r027.disp", bus.display_mode, 1'b1);
            end
            tick(1'b0, 1'b0, 1'b0);
        end
        tick(1'b1, 1'b0, 1'b0);
        chk2("r027.run_sel", bus.sel, 2'b01);
        tick(1'b0, 1'b0, 1'b0);

        tick(1'b0, 1'b1, 1'b0);
        chk1("r028.hset", bus.hset, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        chk1("r028.mset", bus.mset, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        if (SECS) begin
            tick(1'b0, 1'b1, 1'b0);
            chk1("r028.sset", bus.sset, 1'b1);
            tick(1'b0, 1'b0, 1'b0);
        end
        tick(1'b0, 1'b1, 1'b0);
        chk1("r028.cset", bus.cset_pulse, 1'b1);
        chk2("r028.run", bus.sel, 2'b01);
        tick(1'b0, 1'b0, 1'b0);
        chk1("r028.cset_off", bus.cset_pulse, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        chk2("r028.abort_idx", bus.alarm_idx, 2'd0);
        chk2("r028.abort_sel", bus.sel, 2'b00);
        chk1("r028.abort_cset", bus.cset_pulse, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) press(1'b1, 1'b0, 1'b0);

        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        chk1("r029.entry", bus.ahset, 1'b1);
        for (int k = 0; k < 7; k++) begin
            tick(1'b0, 1'b0, 1'b0);
            chk1("r029.early", bus.timeout_pulse, 1'b0);
            chk1("r029.ahset", bus.ahset, 1'b1);
        end
        tick(1'b0, 1'b0, 1'b0);
        chk1("r029.tpulse", bus.timeout_pulse, 1'b1);
        chk2("r029.idx", bus.alarm_idx, 2'd1);
        chk1("r029.ahset_off", bus.ahset, 1'b0);
        chk1("r029.alarm_on", bus.alarm_on, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        chk1("r029.tpulse_off", bus.timeout_pulse, 1'b0);
        for (int k = 0; k < 4; k++) press(1'b1, 1'b0, 1'b0);

        tick(1'b1, 1'b1, 1'b0);
        chk1("r030.no_hset", bus.hset, 1'b0);
        chk2("r030.sel", bus.sel, 2'b00);
        tick(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) press(1'b1, 1'b0, 1'b0);
        ncp = 0;
        for (int k = 0; k < 20; k++) begin
            tick(1'b0, 1'b1, 1'b0);
            if (k == 0) chk1("r030.hset", bus.hset, 1'b1);
            if (k == 1) chk1("r030.hold", bus.mset, 1'b0);
            if (bus.cset_pulse) ncp++;
        end
        tick(1'b0, 1'b0, 1'b0);
        chk2("r030.ncset", 2'(ncp), 2'd0);
        chk2("r030.sel_end", bus.sel, 2'b01);

        press(1'b0, 1'b0, 1'b1);
        chk1("r020.fmt_run", bus.fmt24, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        chk1("r020.fmt_al", bus.fmt24, 1'b0);
        async_reset();
        chk1("r020.fmt_rst", bus.fmt24, 1'b1);

        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        chk1("r031.amset", bus.amset, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk1("r031.amset_rst", bus.amset, 1'b0);
        chk2("r031.sel", bus.sel, 2'b01);
        chk1("r031.alarm_on", bus.alarm_on, 1'b1);
        chk1("r031.alset", bus.alset_pulse, 1'b0);
        #3 reset_n = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        chk1("r031.alset_after", bus.alset_pulse, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk1("r031.alset_after2", bus.alset_pulse, 1'b0);

        for (int n = 0; n < 4000; n++) begin
            pct = (n < 2000) ? 10 : 4;
            if ($urandom_range(0, 299) == 0) async_reset();
            else tick($urandom_range(0, 99) < pct,
                      $urandom_range(0, 99) < pct + 4,
                      $urandom_range(0, 99) < pct);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clock_mode_ctrl.md
CLOCK_MODE_CTRL -- requirements
Module: clock_mode_ctrl

Interface
REQ-001 SHALL have parameter NUM_ALARMS, default 2: alarm channels, legal 1..4.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000: set-state inactivity timeout in clk cycles; 0 disables the timeout.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports mode, set, h1224  in  1 each  level button inputs, already synchronised to clk.
REQ-006 SHALL have ports clock_on, alarm_on  out  1 each  timekeeping/alarm-compare enables.
REQ-007 SHALL have ports hset, mset, sset, ahset, amset  out  1 each  field-edit enables.
REQ-008 SHALL have ports alarm_idx  out  2  and sel  out  2  (selected alarm channel; display mux select).
REQ-009 SHALL have ports display_mode, fmt24, cset_pulse, alset_pulse, timeout_pulse  out  1 each.

Function
REQ-010 SHALL detect rising edges on mode, set and h1224 against a registered previous sample; a level held high SHALL count as one press.
REQ-011 SHALL update state at the clk edge ending the cycle in which the press is detected; outputs SHALL be a latch-free decode of registered state, so they change one cycle after the press.
REQ-012 SHALL implement states RUN, C_SET_H, C_SET_M, C_SET_S, AL_VIEW, AL_SET_H, AL_SET_M, STOPWATCH, ALT_DISPLAY.
REQ-013 mode press: RUN/C_SET_* -> AL_VIEW with idx=0; AL_VIEW/AL_SET_* -> AL_VIEW with idx+1 while idx<NUM_ALARMS-1, else STOPWATCH; STOPWATCH -> ALT_DISPLAY; ALT_DISPLAY -> RUN.
REQ-014 set press: RUN->C_SET_H->C_SET_M->C_SET_S->RUN; AL_VIEW->AL_SET_H->AL_SET_M->AL_VIEW; ignored in STOPWATCH and ALT_DISPLAY.
REQ-015 cset_pulse SHALL be high exactly one cycle after the set press that leaves the last clock-set state to RUN; alset_pulse likewise after AL_SET_M->AL_VIEW.
REQ-016 Leaving a set state via mode or timeout SHALL abort without commit pulse.
REQ-017 Simultaneous mode and set presses: mode wins, set is discarded.
REQ-018 Decode (unlisted outputs 0): RUN clock_on=1, alarm_on=1, sel=01; C_SET_H/M/S hset/mset/sset=1 respectively, sel=01; AL_VIEW clock_on=1, alarm_on=1, sel=00; AL_SET_H/M clock_on=1, ahset/amset=1, sel=00; STOPWATCH clock_on=1, alarm_on=1, sel=11; ALT_DISPLAY clock_on=1, alarm_on=1, display_mode=1, sel=10.
REQ-019 alarm_idx SHALL show idx in AL_* states, 0 elsewhere; idx SHALL never exceed NUM_ALARMS-1.
REQ-020 h1224 press SHALL toggle fmt24 only in RUN; ignored elsewhere.
REQ-021 Inactivity counter SHALL clear on any press or state change; on reaching TIMEOUT_CYCLES-1 in C_SET_* go to RUN, in AL_SET_* go to AL_VIEW (idx kept), with timeout_pulse high one cycle.
REQ-022 Timeout and a press in the same cycle: the press wins, counter clears.

Reset
REQ-023 reset_n low SHALL immediately force state RUN, idx=0, fmt24=1, counter=0, edge registers=0, all pulses 0, outputs per RUN decode.
REQ-024 Reset mid-set SHALL produce no commit pulse; the first press after release SHALL need a fresh rising edge.

Configuration
REQ-025 Macro CLOCK_SECONDS_SET_EN defined: C_SET_S present per REQ-014; undefined: C_SET_S absent, C_SET_M->RUN on set with cset_pulse, sset tied 0.

Verification
REQ-026 Reset release, no input -> RUN, clock_on=1, alarm_on=1, sel=01, fmt24=1.
REQ-027 NUM_ALARMS=3, 5 mode presses -> AL_VIEW idx 0,1,2, STOPWATCH (sel=11), ALT_DISPLAY (display_mode=1); 6th -> RUN.
REQ-028 set x3 from RUN (macro defined) -> hset, mset, sset; 4th set -> RUN with cset_pulse one cycle; mode during C_SET_M -> AL_VIEW idx=0, no cset_pulse.
REQ-029 TIMEOUT_CYCLES=8, enter AL_SET_H idx=1, idle -> AL_VIEW idx=1 with timeout_pulse exactly 8 cycles after entry.
REQ-030 mode and set rising same cycle in RUN -> AL_VIEW, no hset; set held high 20 cycles -> single transition.
REQ-031 reset_n low mid-cycle in AL_SET_M -> outputs RUN decode before next clk edge, alset_pulse never asserted.
